// File: rtl/pulse_param_sync.sv
// Synchronises SPI-side parameter strobes and commits Ton/Toff/Ip/waveform atomically on period boundaries.
// Optional range checking of captured values is enabled by defining PARAM_RANGE_CHECK_EN.
module pulse_param_sync #(
   parameter int SYNC_STAGES  = 3,
   parameter int TON_DEFAULT  = 80,
   parameter int TOFF_DEFAULT = 20,
   parameter int IP_DEFAULT   = 30,
   parameter int WAVE_DEFAULT = 0,
   parameter int TON_MIN      = 1,
   parameter int TON_MAX      = 1000,
   parameter int TOFF_MIN     = 1,
   parameter int TOFF_MAX     = 1000,
   parameter int IP_MAX       = 100,
   parameter int WAVE_MAX     = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        machine_start_ack,
   input  logic        machine_stop_ack,
   input  logic [15:0] Ton_data_async,
   input  logic        change_Ton_ack,
   input  logic [15:0] Toff_data_async,
   input  logic        change_Toff_ack,
   input  logic [15:0] Ip_data_async,
   input  logic        change_Ip_ack,
   input  logic [15:0] waveform_data_async,
   input  logic        change_waveform_ack,
   input  logic        period_end,
   output logic        machine_on,
   output logic [15:0] Ton,
   output logic [15:0] Toff,
   output logic [15:0] Ip,
   output logic [15:0] waveform,
   output logic [3:0]  param_pending,
   output logic        param_update,
   output logic        param_reject
);

   localparam int NF = 4;
   localparam int NA = 6;
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_HOLD   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   localparam logic [NF-1:0][15:0] DEFAULTS = {16'(WAVE_DEFAULT), 16'(IP_DEFAULT),
                                               16'(TOFF_DEFAULT), 16'(TON_DEFAULT)};

   // Field index order matches param_pending: 0 Ton, 1 Toff, 2 Ip, 3 waveform, 4 start, 5 stop
   logic [NA-1:0]                  ack_in;
   logic [NA-1:0][SYNC_STAGES-1:0] sync_q;
   logic [NA-1:0]                  prev_q;
   logic [NA-1:0]                  evt;
   logic [NF-1:0][15:0]            data_in;

   assign ack_in  = {machine_stop_ack, machine_start_ack, change_waveform_ack,
                     change_Ip_ack, change_Toff_ack, change_Ton_ack};
   assign data_in = {waveform_data_async, Ip_data_async, Toff_data_async, Ton_data_async};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         for (int i = 0; i < NA; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], ack_in[i]};
            prev_q[i] <= sync_q[i][SYNC_STAGES-1];
         end
      end
   end

   always_comb begin
      evt = '0;
      for (int i = 0; i < NA; i++)
         evt[i] = sync_q[i][SYNC_STAGES-1] & ~prev_q[i];
   end

   function automatic logic in_range(input int f, input logic [15:0] v);
      logic [31:0] w;
      w = {16'd0, v};
      case (f)
         0:       return (w >= 32'(TON_MIN))  && (w <= 32'(TON_MAX));
         1:       return (w >= 32'(TOFF_MIN)) && (w <= 32'(TOFF_MAX));
         2:       return w <= 32'(IP_MAX);
         default: return w <= 32'(WAVE_MAX);
      endcase
   endfunction

   // Data is sampled only on the synchronised event, when the sender guarantees it is stable
   logic [NF-1:0][15:0] cap_q;
   logic [NF-1:0]       chk_q;
   logic [NF-1:0]       ok;
   logic [NF-1:0]       accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         cap_q <= '0;
         chk_q <= '0;
      end else begin
         chk_q <= evt[NF-1:0];
         for (int f = 0; f < NF; f++)
            if (evt[f]) cap_q[f] <= data_in[f];
      end
   end

`ifdef PARAM_RANGE_CHECK_EN
   for (genvar g = 0; g < NF; g++) begin : g_rng
      assign ok[g] = in_range(g, cap_q[g]);
   end

   logic reject_q;
   always_ff @(posedge clk) begin
      if (rst) reject_q <= 1'b0;
      else     reject_q <= |(chk_q & ~ok);
   end
   assign param_reject = reject_q;
`else
   assign ok           = '1;
   assign param_reject = 1'b0;
`endif

   assign accept = chk_q & ok;

   logic [NF-1:0][15:0] shadow_q;
   logic [NF-1:0][15:0] active_q;
   logic [NF-1:0]       pending_q;
   logic [NF-1:0]       commit_mask;
   logic [1:0]          state_q, state_nxt;
   logic                commit_go;
   logic                machine_on_q;
   logic                update_q;

   // The commit happens on the edge that enters COMMIT; COMMIT itself is a one-cycle cool-down
   always_comb begin
      state_nxt = state_q;
      commit_go = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|pending_q) begin
               if (machine_on_q) begin
                  state_nxt = S_HOLD;
               end else begin
                  commit_go = 1'b1;
                  state_nxt = S_COMMIT;
               end
            end
         end
         S_HOLD: begin
            if (period_end || !machine_on_q) begin
               commit_go = 1'b1;
               state_nxt = S_COMMIT;
            end
         end
         S_COMMIT: state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign commit_mask = commit_go ? pending_q : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         machine_on_q <= 1'b0;
         shadow_q     <= DEFAULTS;
         active_q     <= DEFAULTS;
         pending_q    <= '0;
         update_q     <= 1'b0;
         state_q      <= S_IDLE;
      end else begin
         if (evt[5])      machine_on_q <= 1'b0;
         else if (evt[4]) machine_on_q <= 1'b1;
         // A field accepted on the commit edge keeps its pending bit and waits for the next commit
         for (int f = 0; f < NF; f++) begin
            if (accept[f])      shadow_q[f] <= cap_q[f];
            if (commit_mask[f]) active_q[f] <= shadow_q[f];
         end
         pending_q <= (pending_q & ~commit_mask) | accept;
         update_q  <= commit_go;
         state_q   <= state_nxt;
      end
   end

   assign machine_on    = machine_on_q;
   assign Ton           = active_q[0];
   assign Toff          = active_q[1];
   assign Ip            = active_q[2];
   assign waveform      = active_q[3];
   assign param_pending = pending_q;
   assign param_update  = update_q;

endmodule

// File: tb/tb_pulse_param_sync.sv
// Scoreboard bench for pulse_param_sync: stimulus pushes expected parameter sets, a monitor pops on param_update.
module tb_pulse_param_sync;
   localparam int SS = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        start_ack = 1'b0, stop_ack = 1'b0, period_end = 1'b0;
   logic [3:0]  fack = '0;
   logic [15:0] dat [4];
   logic        machine_on, param_update, param_reject;
   logic [15:0] Ton, Toff, Ip, waveform;
   logic [3:0]  param_pending;

   pulse_param_sync #(.SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst),
      .machine_start_ack(start_ack), .machine_stop_ack(stop_ack),
      .Ton_data_async(dat[0]), .change_Ton_ack(fack[0]),
      .Toff_data_async(dat[1]), .change_Toff_ack(fack[1]),
      .Ip_data_async(dat[2]), .change_Ip_ack(fack[2]),
      .waveform_data_async(dat[3]), .change_waveform_ack(fack[3]),
      .period_end(period_end), .machine_on(machine_on),
      .Ton(Ton), .Toff(Toff), .Ip(Ip), .waveform(waveform),
      .param_pending(param_pending), .param_update(param_update), .param_reject(param_reject)
   );

   typedef logic [3:0][15:0] pset_t;
   pset_t exp_q[$];
   pset_t act_m, prev_set, popped;
   int    rej_exp = 0;
   int    checks = 0, errors = 0;
   bit    mon_en = 1'b0;

   function automatic pset_t cur();
      return {waveform, Ip, Toff, Ton};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   function automatic logic [15:0] rand_valid(input int f);
      case (f)
         0, 1:    return 16'($urandom_range(1, 1000));
         2:       return 16'($urandom_range(0, 100));
         default: return 16'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic send(input int f, input logic [15:0] v);
      dat[f]  = v;
      fack[f] = 1'b1;
      tick(4);
      fack[f] = 1'b0;
      tick(SS + 3);
   endtask

   task automatic mach_ack(input logic s, input logic p);
      start_ack = s; stop_ack = p;
      tick(4);
      start_ack = 1'b0; stop_ack = 1'b0;
      tick(SS + 2);
   endtask

   task automatic pend_pulse();
      period_end = 1'b1;
      tick();
      period_end = 1'b0;
      tick(2);
   endtask

   initial begin
      for (int i = 0; i < 4; i++) dat[i] = '0;
      fork
         forever begin
            @(posedge clk); #1;
            if (mon_en) begin
               if (param_update) begin
                  chk("update_expected", 64'(exp_q.size() != 0), 64'd1);
                  if (exp_q.size() != 0) begin
                     popped = exp_q.pop_front();
                     chk("commit_set", cur(), popped);
                  end
               end else begin
                  chk("no_change_without_update", cur(), prev_set);
               end
               if (param_reject) begin
                  chk("reject_expected", 64'(rej_exp != 0), 64'd1);
                  if (rej_exp != 0) rej_exp--;
               end
            end
            prev_set = cur();
         end
      join_none

      // Reset state
      tick(3);
      chk("rst_ton", Ton, 80);
      chk("rst_toff", Toff, 20);
      chk("rst_ip", Ip, 30);
      chk("rst_wave", waveform, 0);
      chk("rst_pending", param_pending, 0);
      chk("rst_update", param_update, 0);
      chk("rst_reject", param_reject, 0);
      chk("rst_machine_on", machine_on, 0);
      rst = 1'b0;
      act_m = {16'd0, 16'd30, 16'd20, 16'd80};
      tick();
      mon_en = 1'b1;

      // Stopped machine: Ton lands SS+3 cycles after the ack rises
      act_m[0] = 16'd150;
      exp_q.push_back(act_m);
      dat[0] = 16'd150; fack[0] = 1'b1;
      tick(4);
      fack[0] = 1'b0;
      tick(SS - 2);
      chk("t1_ton_before", Ton, 80);
      tick();
      chk("t1_ton_latency", Ton, 150);
      chk("t1_update_pulse", param_update, 1);
      chk("t1_others", cur(), {16'd0, 16'd30, 16'd20, 16'd150});
      tick(4);

      for (int i = 0; i < 6; i++) begin
         int f;
         logic [15:0] v;
         f = $urandom_range(0, 3);
         v = rand_valid(f);
         act_m[f] = v;
         exp_q.push_back(act_m);
         send(f, v);
         chk("idle_random_update", cur(), act_m);
      end

      // Running: commits wait for period_end
      mach_ack(1'b1, 1'b0);
      chk("machine_on_start", machine_on, 1);
      begin
         logic [15:0] v;
         v = 16'($urandom_range(1, 1000));
         send(1, v);
         chk("t2_pending", param_pending, 4'b0010);
         chk("t2_toff_held", Toff, act_m[1]);
         tick(5);
         chk("t2_toff_still_held", Toff, act_m[1]);
         act_m[1] = v;
         exp_q.push_back(act_m);
         pend_pulse();
         chk("t2_toff_committed", Toff, v);
         chk("t2_pending_clear", param_pending, 0);
      end

      begin
         logic [15:0] vt, vi;
         vt = rand_valid(0); vi = rand_valid(2);
         send(0, vt);
         send(2, vi);
         chk("t3_pending", param_pending, 4'b0101);
         chk("t3_held", cur(), act_m);
         act_m[0] = vt; act_m[2] = vi;
         exp_q.push_back(act_m);
         pend_pulse();
         chk("t3_both", cur(), act_m);
      end

      for (int i = 0; i < 3; i++) begin
         int f;
         logic [15:0] v;
         f = $urandom_range(0, 3);
         v = rand_valid(f);
         send(f, v);
         chk("run_random_held", cur(), act_m);
         act_m[f] = v;
         exp_q.push_back(act_m);
         pend_pulse();
         chk("run_random_commit", cur(), act_m);
      end

`ifdef PARAM_RANGE_CHECK_EN
      begin
         int          tf [6] = '{2, 0, 1, 3, 0, 2};
         logic [15:0] tv [6] = '{16'd500, 16'd0, 16'd1001, 16'd4, 16'd1000, 16'd100};
         bit          tok [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
         for (int i = 0; i < 6; i++) begin
            if (tok[i]) begin
               send(tf[i], tv[i]);
               act_m[tf[i]] = tv[i];
               exp_q.push_back(act_m);
               pend_pulse();
               chk("range_accept", cur(), act_m);
            end else begin
               rej_exp++;
               send(tf[i], tv[i]);
               chk("range_reject_pending", param_pending, 0);
               chk("range_reject_seen", rej_exp, 0);
               chk("range_reject_held", cur(), act_m);
            end
         end
      end
`else
      send(2, 16'd500);
      act_m[2] = 16'd500;
      exp_q.push_back(act_m);
      pend_pulse();
      chk("ip_500_accepted", Ip, 500);
`endif

      // Waveform accepted on the commit edge stays pending for the next period
      begin
         logic [15:0] vt, w;
         vt = rand_valid(0);
         w  = 16'((32'(act_m[3]) + 1 + $urandom_range(0, 2)) % 4);
         send(0, vt);
         chk("t6_ton_pending", param_pending, 4'b0001);
         act_m[0] = vt;
         exp_q.push_back(act_m);
         dat[3] = w; fack[3] = 1'b1;
         tick(SS + 1);
         fack[3] = 1'b0;
         period_end = 1'b1;
         tick();
         period_end = 1'b0;
         chk("t6_commit_pulse", param_update, 1);
         chk("t6_wave_pending", param_pending, 4'b1000);
         tick(3);
         chk("t6_wave_held", waveform, act_m[3]);
         chk("t6_wave_still_pending", param_pending, 4'b1000);
         act_m[3] = w;
         exp_q.push_back(act_m);
         pend_pulse();
         chk("t6_wave_committed", waveform, w);
         chk("t6_pending_clear", param_pending, 0);
      end

      // Stop while Ton waits in HOLD commits without period_end
      begin
         logic [15:0] v;
         v = rand_valid(0);
         send(0, v);
         chk("t5_hold_pending", param_pending, 4'b0001);
         act_m[0] = v;
         exp_q.push_back(act_m);
         mach_ack(1'b0, 1'b1);
         chk("t5_machine_off", machine_on, 0);
         chk("t5_ton_committed", Ton, v);
         chk("t5_pending_clear", param_pending, 0);
      end

      start_ack = 1'b1; stop_ack = 1'b1;
      for (int i = 0; i < SS + 6; i++) begin
         if (i == 4) begin start_ack = 1'b0; stop_ack = 1'b0; end
         tick();
         chk("start_stop_same_cycle", machine_on, 0);
      end

      // Reset mid-update discards the captured value
      dat[0] = 16'd777; fack[0] = 1'b1;
      tick(SS + 1);
      mon_en = 1'b0;
      rst = 1'b1;
      fack[0] = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(SS + 6);
      chk("midreset_ton", Ton, 80);
      chk("midreset_pending", param_pending, 0);
      chk("midreset_defaults", cur(), {16'd0, 16'd30, 16'd20, 16'd80});

      chk("scoreboard_drained", exp_q.size(), 0);
      chk("rejects_drained", rej_exp, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
